// File: rtl/uart_tx_frame.sv
// uart_tx_frame: asynchronous serial transmitter paced by an external bit-rate tick.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits.
module uart_tx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_bps_tick,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_txd,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [CNT_W-1:0]     r_bit_cnt, w_bit_cnt_nxt;
    logic [1:0]           r_stop_cnt, w_stop_cnt_nxt;
    logic                 r_parity, w_parity_nxt;
    logic                 r_txd, w_txd_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_ready;
    logic                 r_busy;
    logic                 w_par_odd;

    assign w_par_odd = (PARITY_ODD != 0);

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_parity_nxt   = r_parity;
        w_txd_nxt      = r_txd;
        w_done_nxt     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_txd_nxt = 1'b1;
                if (i_valid) begin
                    w_shift_nxt   = i_data;
                    w_parity_nxt  = (^i_data) ^ w_par_odd;
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_bps_tick) begin
                    w_txd_nxt   = 1'b0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (i_bps_tick) begin
                    w_txd_nxt     = r_shift[0];
                    w_shift_nxt   = r_shift >> 1;
                    w_bit_cnt_nxt = CNT_W'(1);
                    w_state_nxt   = S_DATA;
                end
            end
            S_DATA: begin
                // The shift register always presents the next data bit at position 0.
                if (i_bps_tick) begin
                    if (r_bit_cnt < CNT_W'(DATA_BITS)) begin
                        w_txd_nxt     = r_shift[0];
                        w_shift_nxt   = r_shift >> 1;
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end else if (PARITY_EN != 0) begin
                        w_txd_nxt   = r_parity;
                        w_state_nxt = S_PARITY;
                    end else begin
                        w_txd_nxt      = 1'b1;
                        w_stop_cnt_nxt = 2'd1;
                        w_state_nxt    = S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (i_bps_tick) begin
                    w_txd_nxt      = 1'b1;
                    w_stop_cnt_nxt = 2'd1;
                    w_state_nxt    = S_STOP;
                end
            end
            S_STOP: begin
                if (i_bps_tick) begin
                    if (r_stop_cnt < 2'(STOP_BITS)) begin
                        w_stop_cnt_nxt = r_stop_cnt + 2'd1;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_txd_nxt   = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Ready/busy are registered from the next state so they track the state register exactly.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
            r_parity   <= 1'b0;
            r_txd      <= 1'b1;
            r_done     <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_parity   <= w_parity_nxt;
            r_txd      <= w_txd_nxt;
            r_done     <= w_done_nxt;
            r_ready    <= (w_state_nxt == S_IDLE);
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

    assign o_ready = r_ready;
    assign o_txd   = r_txd;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule
